rvh_l1d_refill_collector: RTL and testbench



---
 rtl/rvh_l1d_pkg.sv | 32 +++
 rtl/mp_fifo.sv | 54 +++++
 rtl/rvh_l1d_refill_collector.sv | 146 ++++++++++++++
 tb/tb_rvh_l1d_refill_collector.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types and sizes: MSHR ids, refill burst geometry and the
// line-fill buffer entry carried from the R channel to the refill stage.
package rvh_l1d_pkg;

    localparam int N_MSHR     = 4;
    localparam int N_MSHR_W   = $clog2(N_MSHR);
    localparam int BURST_SIZE = 4;
    localparam int BEAT_W     = 64;
    localparam int LINE_W     = BURST_SIZE * BEAT_W;
    localparam int N_LFB      = 2;
    localparam int BEAT_IDX_W = $clog2(BURST_SIZE);
    localparam int LFB_CNT_W  = $clog2(N_LFB + 1);

    typedef logic [N_MSHR_W-1:0]   mshr_id_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
    typedef logic [LFB_CNT_W-1:0]  lfb_cnt_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BURST_SIZE - 1);
    localparam lfb_cnt_t  LFB_FULL  = lfb_cnt_t'(N_LFB);

    typedef struct packed {
        mshr_id_t          mshr_id;
        logic [LINE_W-1:0] line;
        logic              err;
    } lfb_entry_t;

    typedef enum logic {
        ASM_IDLE,
        ASM_FILL
    } asm_state_t;

endpackage

// File: rtl/mp_fifo.sv
// Generic single-enqueue / single-dequeue ring buffer with an occupancy count.
// The head entry is presented combinationally; storage clears on reset.
module mp_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enq,
    input  T                             enq_data,
    input  logic                         deq,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap at DEPTH so non power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rvh_l1d_refill_collector.sv
// Collects R-channel beats into whole cache lines, queues finished lines,
// hands them to the refill stage and then frees the owning MSHR entry.
module rvh_l1d_refill_collector
    import rvh_l1d_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_resp_if_rvalid,
    output logic                l2_resp_if_rready,
    input  logic [N_MSHR_W-1:0] l2_resp_if_rid_tid,
    input  logic [BEAT_W-1:0]   l2_resp_if_rdata,
    input  logic [1:0]          l2_resp_if_rresp,
    input  logic                l2_resp_if_rlast,
    output logic                refill_valid_o,
    input  logic                refill_ready_i,
    output logic [N_MSHR_W-1:0] refill_mshr_id_o,
    output logic [LINE_W-1:0]   refill_line_o,
    output logic                refill_err_o,
    output logic                mlfb_mshr_dealloc_valid_o,
    output logic [N_MSHR_W-1:0] mlfb_mshr_dealloc_idx_o,
    input  logic                mlfb_mshr_dealloc_ready_i,
    output logic                protocol_err_o
);

    asm_state_t        state_q, state_d;
    beat_idx_t         cnt_q, cnt_d;
    mshr_id_t          tid_q, tid_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              err_q, err_d;
    logic              perr_q, perr_d;

    logic              beat_hs;
    logic              push;
    logic              pop;
    lfb_entry_t        push_entry;
    lfb_entry_t        head;
    lfb_cnt_t          lfb_count;
    logic              dealloc_pending_q;
    mshr_id_t          dealloc_idx_q;

    // Space is judged from the registered count only, so a push is always safe.
    assign l2_resp_if_rready = ~rst & (lfb_count != LFB_FULL);
    assign beat_hs           = l2_resp_if_rvalid & l2_resp_if_rready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tid_d      = tid_q;
        line_d     = line_q;
        err_d      = err_q;
        perr_d     = perr_q;
        push       = 1'b0;
        push_entry = '0;

        if (beat_hs) begin
            // A new burst starts from a zeroed line so short bursts leave no stale slices.
            if (state_q == ASM_IDLE) begin
                line_d = '0;
                err_d  = |l2_resp_if_rresp;
                tid_d  = l2_resp_if_rid_tid;
            end else begin
                err_d = err_q | (|l2_resp_if_rresp);
                if (l2_resp_if_rid_tid != tid_q) begin
                    perr_d = 1'b1;
                end
            end
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = l2_resp_if_rdata;

            if (l2_resp_if_rlast && (cnt_q != LAST_BEAT)) begin
                perr_d = 1'b1;
            end
            if (!l2_resp_if_rlast && (cnt_q == LAST_BEAT)) begin
                perr_d = 1'b1;
            end

            if (l2_resp_if_rlast) begin
                push               = 1'b1;
                push_entry.mshr_id = tid_d;
                push_entry.line    = line_d;
                push_entry.err     = err_d;
                state_d            = ASM_IDLE;
                cnt_d              = '0;
            end else begin
                state_d = ASM_FILL;
                if (cnt_q != LAST_BEAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ASM_IDLE;
            cnt_q   <= '0;
            tid_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
            line_q  <= line_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end

    mp_fifo #(
        .T     (lfb_entry_t),
        .DEPTH (N_LFB)
    ) u_lfb_ring (
        .clk      (clk),
        .rst      (rst),
        .enq      (push),
        .enq_data (push_entry),
        .deq      (pop),
        .head     (head),
        .count    (lfb_count)
    );

    // The next line is held back until the previous owner has been freed.
    assign refill_valid_o   = (lfb_count != '0) & ~dealloc_pending_q;
    assign pop              = refill_valid_o & refill_ready_i;
    assign refill_mshr_id_o = head.mshr_id;
    assign refill_line_o    = head.line;
    assign refill_err_o     = head.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            dealloc_pending_q <= 1'b0;
            dealloc_idx_q     <= '0;
        end else if (pop) begin
            dealloc_pending_q <= 1'b1;
            dealloc_idx_q     <= head.mshr_id;
        end else if (mlfb_mshr_dealloc_ready_i) begin
            dealloc_pending_q <= 1'b0;
        end
    end

    assign mlfb_mshr_dealloc_valid_o = dealloc_pending_q;
    assign mlfb_mshr_dealloc_idx_o   = dealloc_idx_q;
    assign protocol_err_o            = perr_q;

endmodule

// File: tb/tb_rvh_l1d_refill_collector.sv
// Randomized bench for the refill collector against a queue-based line model.
module tb_rvh_l1d_refill_collector;
    import rvh_l1d_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rvalid = 1'b0;
    logic                rready;
    logic [N_MSHR_W-1:0] rid = '0;
    logic [BEAT_W-1:0]   rdata = '0;
    logic [1:0]          rresp = '0;
    logic                rlast = 1'b0;
    logic                refill_valid;
    logic                refill_ready = 1'b0;
    logic [N_MSHR_W-1:0] refill_id;
    logic [LINE_W-1:0]   refill_line;
    logic                refill_err;
    logic                dl_valid;
    logic [N_MSHR_W-1:0] dl_idx;
    logic                dl_ready = 1'b0;
    logic                perr;

    rvh_l1d_refill_collector dut (
        .clk                       (clk),
        .rst                       (rst),
        .l2_resp_if_rvalid         (rvalid),
        .l2_resp_if_rready         (rready),
        .l2_resp_if_rid_tid        (rid),
        .l2_resp_if_rdata          (rdata),
        .l2_resp_if_rresp          (rresp),
        .l2_resp_if_rlast          (rlast),
        .refill_valid_o            (refill_valid),
        .refill_ready_i            (refill_ready),
        .refill_mshr_id_o          (refill_id),
        .refill_line_o             (refill_line),
        .refill_err_o              (refill_err),
        .mlfb_mshr_dealloc_valid_o (dl_valid),
        .mlfb_mshr_dealloc_idx_o   (dl_idx),
        .mlfb_mshr_dealloc_ready_i (dl_ready),
        .protocol_err_o            (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_MSHR_W-1:0] tid;
        logic [BEAT_W-1:0]   data;
        logic [1:0]          resp;
        logic                last;
    } beat_t;

    typedef struct {
        logic [N_MSHR_W-1:0] id;
        logic [LINE_W-1:0]   line;
        logic                err;
    } line_t;

    beat_t               gen_q[$];
    line_t               exp_q[$];
    logic [BEAT_W-1:0]   cur_beats[$];
    logic [N_MSHR_W-1:0] cur_tid = '0;
    logic                cur_err = 1'b0;
    bit                  pend = 1'b0;
    logic [N_MSHR_W-1:0] pend_idx = '0;
    bit                  exp_perr = 1'b0;

    int valid_pct   = 100;
    int refill_pct  = 100;
    int dealloc_pct = 100;
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs,
                               input logic [LINE_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addBurst(input logic [N_MSHR_W-1:0] tid, input int len, input int flip_at,
                            input int err_beat, input logic [BEAT_W-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.tid  = (flip_at >= 0 && k >= flip_at) ? tid + 1'b1 : tid;
            b.data = (base != '0) ? base * BEAT_W'(k + 1) : {$urandom, $urandom};
            b.resp = (k == err_beat) ? 2'($urandom_range(1, 3)) : 2'b00;
            b.last = (k == len - 1);
            gen_q.push_back(b);
        end
    endtask

    task automatic applyStimulus(input int n_bursts, input int bad_pct);
        int len, flip, errb;
        for (int n = 0; n < n_bursts; n++) begin
            len  = BURST_SIZE;
            flip = -1;
            errb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BURST_SIZE - 1)) : -1;
            if ($urandom_range(0, 99) < bad_pct) begin
                case ($urandom_range(0, 2))
                    0:       len = $urandom_range(1, BURST_SIZE - 1);
                    1:       len = BURST_SIZE + 1;
                    default: flip = $urandom_range(1, BURST_SIZE - 1);
                endcase
            end
            addBurst(N_MSHR_W'($urandom_range(0, N_MSHR - 1)), len, flip, errb, '0);
        end
    endtask

    // Line as seen from the beat list: beat k lands in slot k, extras pile into the last slot.
    function automatic logic [LINE_W-1:0] buildLine();
        logic [LINE_W-1:0] l = '0;
        int slot;
        for (int k = 0; k < cur_beats.size(); k++) begin
            slot = (k < BURST_SIZE) ? k : BURST_SIZE - 1;
            l[slot * BEAT_W +: BEAT_W] = cur_beats[k];
        end
        return l;
    endfunction

    task automatic stepCycle();
        bit    exp_rready, bhs, rf_hs, dl_clr;
        beat_t b;
        line_t e;
        if (gen_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            b      = gen_q[0];
            rvalid = 1'b1;
            rid    = b.tid;
            rdata  = b.data;
            rresp  = b.resp;
            rlast  = b.last;
        end else begin
            rvalid = 1'b0;
            rid    = N_MSHR_W'($urandom);
            rdata  = {$urandom, $urandom};
            rresp  = 2'($urandom);
            rlast  = 1'($urandom);
        end
        refill_ready = ($urandom_range(0, 99) < refill_pct);
        dl_ready     = ($urandom_range(0, 99) < dealloc_pct);
        #2;
        exp_rready = !rst && (exp_q.size() != N_LFB);
        checkOutput("rready", rready, exp_rready);
        bhs    = rvalid && exp_rready;
        rf_hs  = !rst && exp_q.size() != 0 && !pend && refill_ready;
        dl_clr = pend && dl_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            cur_beats.delete();
            pend     = 1'b0;
            pend_idx = '0;
            exp_perr = 1'b0;
        end else begin
            if (dl_clr) pend = 1'b0;
            if (rf_hs) begin
                pend     = 1'b1;
                pend_idx = exp_q[0].id;
                void'(exp_q.pop_front());
            end
            if (bhs) begin
                b = gen_q.pop_front();
                if (cur_beats.size() == 0) begin
                    cur_tid = b.tid;
                    cur_err = 1'b0;
                end else if (b.tid != cur_tid) begin
                    exp_perr = 1'b1;
                end
                cur_err = cur_err | (b.resp != 2'b00);
                if (b.last != (cur_beats.size() >= BURST_SIZE - 1)) exp_perr = 1'b1;
                cur_beats.push_back(b.data);
                if (b.last) begin
                    e.id   = cur_tid;
                    e.line = buildLine();
                    e.err  = cur_err;
                    exp_q.push_back(e);
                    cur_beats.delete();
                end
            end
        end
        #1;
        checkOutput("refill_valid", refill_valid, exp_q.size() != 0 && !pend);
        if (exp_q.size() != 0 && !pend) begin
            checkOutput("refill_id", refill_id, exp_q[0].id);
            checkOutput("refill_line", refill_line, exp_q[0].line);
            checkOutput("refill_err", refill_err, exp_q[0].err);
        end
        checkOutput("dealloc_valid", dl_valid, pend);
        checkOutput("dealloc_idx", dl_idx, pend_idx);
        checkOutput("protocol_err", perr, exp_perr);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) stepCycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((gen_q.size() != 0 || exp_q.size() != 0 || pend) && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, (gen_q.size() == 0 && exp_q.size() == 0 && !pend), 1);
    endtask

    initial begin
        logic [LINE_W-1:0] tp1_line;
        int                n;

        valid_pct = 0;
        doReset();
        checkOutput("rst_line", refill_line, '0);
        checkOutput("rst_id", refill_id, '0);
        checkOutput("rst_err", refill_err, '0);

        // Single clean burst: latency and one-shot dealloc.
        valid_pct   = 100;
        refill_pct  = 100;
        dealloc_pct = 100;
        addBurst(2'd2, BURST_SIZE, -1, -1, 64'h1111111111111111);
        repeat (4) stepCycle();
        tp1_line = {64'h4444444444444444, 64'h3333333333333333,
                    64'h2222222222222222, 64'h1111111111111111};
        checkOutput("tp1_valid", refill_valid, 1);
        checkOutput("tp1_line", refill_line, tp1_line);
        checkOutput("tp1_id", refill_id, 2);
        checkOutput("tp1_err", refill_err, 0);
        stepCycle();
        checkOutput("tp1_dealloc_valid", dl_valid, 1);
        checkOutput("tp1_dealloc_idx", dl_idx, 2);
        stepCycle();
        checkOutput("tp1_dealloc_once", dl_valid, 0);

        // Ring fills to N_LFB and back-pressures the third burst.
        refill_pct = 0;
        addBurst(2'd0, BURST_SIZE, -1, -1, '0);
        addBurst(2'd1, BURST_SIZE, -1, -1, '0);
        addBurst(2'd2, BURST_SIZE, -1, -1, '0);
        repeat (20) stepCycle();
        checkOutput("tp2_stall_rready", rready, 0);
        refill_pct = 100;
        drain("tp2_drain", 60);

        // Error response on one beat taints only that line.
        addBurst(2'd3, BURST_SIZE, -1, 1, '0);
        addBurst(2'd1, BURST_SIZE, -1, -1, '0);
        drain("tp3_drain", 40);

        // Early rlast and mid-burst tid change.
        addBurst(2'd1, BURST_SIZE - 1, -1, -1, '0);
        drain("tp4_drain", 30);
        checkOutput("tp4_perr", perr, 1);
        repeat (3) stepCycle();
        checkOutput("tp4_perr_sticky", perr, 1);
        doReset();
        checkOutput("tp4_perr_cleared", perr, 0);
        addBurst(2'd0, BURST_SIZE, 2, -1, '0);
        drain("tp4b_drain", 30);
        checkOutput("tp4_tid_perr", perr, 1);
        doReset();

        // Dealloc back-pressure holds off the next refill.
        dealloc_pct = 0;
        addBurst(2'd2, BURST_SIZE, -1, -1, '0);
        addBurst(2'd3, BURST_SIZE, -1, -1, '0);
        repeat (12) stepCycle();
        checkOutput("tp5_refill_blocked", refill_valid, 0);
        checkOutput("tp5_dealloc_held", dl_valid, 1);
        checkOutput("tp5_dealloc_idx", dl_idx, 2);
        dealloc_pct = 100;
        drain("tp5_drain", 40);

        // Reset with one line buffered and a burst half received.
        refill_pct = 0;
        addBurst(2'd1, BURST_SIZE, -1, -1, '0);
        addBurst(2'd2, BURST_SIZE, -1, -1, '0);
        n = 0;
        while (gen_q.size() > BURST_SIZE - 2 && n < 30) begin
            stepCycle();
            n++;
        end
        checkOutput("tp6_setup", gen_q.size() == BURST_SIZE - 2, 1);
        rst = 1'b1;
        stepCycle();
        checkOutput("tp6_rready_in_rst", rready, 0);
        checkOutput("tp6_refill_valid", refill_valid, 0);
        checkOutput("tp6_line", refill_line, '0);
        checkOutput("tp6_dealloc", dl_valid, 0);
        gen_q.delete();
        rst = 1'b0;
        refill_pct = 100;
        addBurst(2'd3, BURST_SIZE, -1, -1, '0);
        drain("tp6_drain", 30);

        // Random clean traffic, then random traffic with malformed bursts.
        valid_pct   = 70;
        refill_pct  = 60;
        dealloc_pct = 70;
        applyStimulus(40, 0);
        drain("rand_clean_drain", 1500);
        checkOutput("rand_clean_perr", perr, 0);
        applyStimulus(40, 30);
        drain("rand_bad_drain", 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
